wisc_trace_buffer: RTL

//  Synthesizable trace and performance-statistics unit for the pipelined WISC core, tapped at writeback.
//  It captures retire events into a DEPTH-entry circular buffer and keeps saturating perf counters.
//  It stops on Halt or on a cycle-limit watchdog, then streams captured entries out oldest-first over valid/ready.

---
 rtl/wisc_trace_buffer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/wisc_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : wisc_trace_buffer
// Brief    : Writeback trace capture into a circular buffer with saturating
//            perf counters; stops on Halt/watchdog, then streams entries out.
// Revision : 1.0 - initial release
// ============================================================================
module wisc_trace_buffer #(
    parameter int ARCH_WIDTH  = 16,
    parameter int REG_WIDTH   = 4,
    parameter int DEPTH       = 16,
    parameter int CNT_WIDTH   = 32,
    parameter int CYCLE_LIMIT = 100000
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic                                Halt,
    input  logic                                Stall,
    input  logic [ARCH_WIDTH-1:0]               PC,
    input  logic [ARCH_WIDTH-1:0]               Inst,
    input  logic                                RegWrite,
    input  logic [REG_WIDTH-1:0]                WriteRegister,
    input  logic [ARCH_WIDTH-1:0]               WriteData,
    input  logic                                MemRead,
    input  logic                                MemWrite,
    input  logic [ARCH_WIDTH-1:0]               MemAddress,
    input  logic [ARCH_WIDTH-1:0]               MemDataIn,
    input  logic [ARCH_WIDTH-1:0]               MemDataOut,
    input  logic                                dump_req,
    input  logic                                rd_ready,
    output logic                                rd_valid,
    output logic [3*ARCH_WIDTH+REG_WIDTH+3:0]   rd_data,
    output logic [$clog2(DEPTH):0]              entry_count,
    output logic [CNT_WIDTH-1:0]                cycle_count,
    output logic [CNT_WIDTH-1:0]                inst_count,
    output logic [CNT_WIDTH-1:0]                load_count,
    output logic [CNT_WIDTH-1:0]                store_count,
    output logic [CNT_WIDTH-1:0]                stall_count,
    output logic                                halted,
    output logic                                timeout,
    output logic                                overflow,
    output logic                                dump_done
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = 3*ARCH_WIDTH + REG_WIDTH + 4;

    localparam logic [1:0] c_RUN  = 2'd0;
    localparam logic [1:0] c_STOP = 2'd1;
    localparam logic [1:0] c_DUMP = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [PTR_W:0]     c_DEPTH    = (PTR_W+1)'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] c_LIMIT_M1 = CNT_WIDTH'(CYCLE_LIMIT - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_nextState;
    logic [ENTRY_W-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wrPtr;
    logic [PTR_W-1:0]      r_rdPtr;
    logic [PTR_W:0]        r_count;
    logic [CNT_WIDTH-1:0]  r_cycleCount;
    logic [CNT_WIDTH-1:0]  r_instCount;
    logic [CNT_WIDTH-1:0]  r_loadCount;
    logic [CNT_WIDTH-1:0]  r_storeCount;
    logic [CNT_WIDTH-1:0]  r_stallCount;
    logic                  r_halted;
    logic                  r_timeout;
    logic                  r_overflow;

    logic                  w_inRun;
    logic                  w_rdValid;
    logic                  w_dumpDone;
    logic                  w_wdFire;
    logic                  w_capture;
    logic                  w_full;
    logic                  w_pop;
    logic [ARCH_WIDTH-1:0] w_capData;

    // The data address is not part of the entry format; folded here so it reads as used.
    logic w_unusedMemAddr;
    assign w_unusedMemAddr = ^MemAddress;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_RUN:   if (Halt || w_wdFire) w_nextState = c_STOP;
            c_STOP:  if (dump_req)         w_nextState = c_DUMP;
            c_DUMP:  if (r_count == '0)    w_nextState = c_DONE;
            default: w_nextState = c_DONE;
        endcase
    end

    // Output decode
    always_comb begin
        w_inRun    = (r_state == c_RUN);
        w_rdValid  = (r_state == c_DUMP) && (r_count != '0);
        w_dumpDone = (r_state == c_DONE);
    end

    assign w_wdFire  = (r_cycleCount == c_LIMIT_M1);
    assign w_capture = w_inRun && en && (Halt || RegWrite || MemRead || MemWrite);
    assign w_full    = (r_count == c_DEPTH);
    assign w_pop     = w_rdValid && rd_ready;
    assign w_capData = RegWrite ? WriteData : (MemWrite ? MemDataIn : MemDataOut);

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_mem[r_wrPtr] <= {PC, Inst, Halt, MemWrite, MemRead, RegWrite, WriteRegister, w_capData};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_count      <= '0;
            r_cycleCount <= '0;
            r_instCount  <= '0;
            r_loadCount  <= '0;
            r_storeCount <= '0;
            r_stallCount <= '0;
            r_halted     <= 1'b0;
            r_timeout    <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            // A full buffer drops its oldest entry to make room for the new one.
            if (w_capture) begin
                r_wrPtr <= r_wrPtr + 1'b1;
                if (w_full) begin
                    r_rdPtr    <= r_rdPtr + 1'b1;
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
                r_count <= r_count - 1'b1;
            end
            if (w_inRun) begin
                if (r_cycleCount != '1)
                    r_cycleCount <= r_cycleCount + 1'b1;
                if ((Halt || RegWrite || MemWrite) && r_instCount != '1)
                    r_instCount <= r_instCount + 1'b1;
                if (MemRead && r_loadCount != '1)
                    r_loadCount <= r_loadCount + 1'b1;
                if (MemWrite && r_storeCount != '1)
                    r_storeCount <= r_storeCount + 1'b1;
                if (Stall && r_stallCount != '1)
                    r_stallCount <= r_stallCount + 1'b1;
                if (Halt)
                    r_halted <= 1'b1;
                else if (w_wdFire)
                    r_timeout <= 1'b1;
            end
        end
    end

    assign rd_valid    = w_rdValid;
    assign rd_data     = w_rdValid ? r_mem[r_rdPtr] : '0;
    assign entry_count = r_count;
    assign cycle_count = r_cycleCount;
    assign inst_count  = r_instCount;
    assign load_count  = r_loadCount;
    assign store_count = r_storeCount;
    assign stall_count = r_stallCount;
    assign halted      = r_halted;
    assign timeout     = r_timeout;
    assign overflow    = r_overflow;
    assign dump_done   = w_dumpDone;

endmodule
`default_nettype wire
